// File: rtl/dma_dsc_credit_tracker.sv
// dma_dsc_credit_tracker
// Per-queue descriptor credit table. Increments add credit, with saturation.
// Consume requests are granted min(requested, available) one cycle after
// acceptance. A clear sweep (FLR) zeroes the table at one queue per cycle.
// Optional statistics counters are built when macro DSC_CRD_STATS_EN is defined.
module dma_dsc_credit_tracker #(
    parameter int NUM_Q = 32,
    parameter int QID_W = 5,
    parameter int CRD_W = 16
) (
    input  logic             axi_aclk,
    input  logic             axi_reset_n,
    input  logic             inc_vld,
    input  logic [QID_W-1:0] inc_qid,
    input  logic [CRD_W-1:0] inc_num,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [QID_W-1:0] req_qid,
    input  logic [CRD_W-1:0] req_num,
    output logic             gnt_vld,
    output logic [QID_W-1:0] gnt_qid,
    output logic [CRD_W-1:0] gnt_num,
    input  logic             clr_start,
    output logic             clr_busy,
    output logic             clr_done,
    output logic [NUM_Q-1:0] avail_vec,
    output logic             sat_err,
    output logic [31:0]      stat_inc_cnt,
    output logic [31:0]      stat_sat_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [CRD_W-1:0] CRD_MAX  = '1;
    localparam logic [QID_W-1:0] LAST_IDX = QID_W'(NUM_Q - 1);

    state_t           state_q, state_d;
    logic [QID_W-1:0] idx_q, idx_d;
    logic [CRD_W-1:0] credit_q [NUM_Q];
    logic [CRD_W-1:0] credit_d [NUM_Q];
    logic [NUM_Q-1:0] avail_q, avail_d;
    logic             rdy_q, rdy_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic [QID_W-1:0] gnt_qid_q, gnt_qid_d;
    logic [CRD_W-1:0] gnt_num_q, gnt_num_d;
    logic             done_q, done_d;
    logic             sat_q, sat_d;

    logic             inc_ok;
    logic             req_acc;
    logic [CRD_W-1:0] req_cur;
    logic [CRD_W-1:0] grant;
    logic [CRD_W-1:0] inc_sum;
    logic             inc_ovf;

    // Saturating add: returns {overflow flag, clipped sum}.
    function automatic logic [CRD_W:0] sat_add(input logic [CRD_W-1:0] a,
                                               input logic [CRD_W-1:0] b);
        logic [CRD_W:0] full;
        full = {1'b0, a} + {1'b0, b};
        if (full[CRD_W]) begin
            return {1'b1, CRD_MAX};
        end
        return {1'b0, full[CRD_W-1:0]};
    endfunction

    // Grant size and increment result, both from the pre-update table.
    always_comb begin
        inc_ok             = inc_vld && (state_q == ST_IDLE);
        req_acc            = req_vld && rdy_q;
        req_cur            = credit_q[req_qid];
        grant              = (req_num < req_cur) ? req_num : req_cur;
        {inc_ovf, inc_sum} = sat_add(credit_q[inc_qid], inc_num);
    end

    // Next credit table: saturate the increment first, then subtract the grant.
    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            credit_d[i] = credit_q[i];
            if (state_q == ST_IDLE) begin
                if (inc_ok && (inc_qid == QID_W'(i))) begin
                    credit_d[i] = inc_sum;
                end
                if (req_acc && (req_qid == QID_W'(i))) begin
                    credit_d[i] = credit_d[i] - grant;
                end
            end else if (idx_q == QID_W'(i)) begin
                credit_d[i] = '0;
            end
            avail_d[i] = |credit_d[i];
        end
    end

    // FSM next state, sweep index and registered control outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        gnt_vld_d = req_acc;
        gnt_qid_d = req_acc ? req_qid : gnt_qid_q;
        gnt_num_d = req_acc ? grant : gnt_num_q;
        sat_d     = inc_ok && inc_ovf;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rdy_d = (state_d == ST_IDLE);
    end

    // State, table and output registers; reset aborts any sweep or pending grant.
    always_ff @(posedge axi_aclk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            avail_q   <= '0;
            rdy_q     <= 1'b0;
            gnt_vld_q <= 1'b0;
            gnt_qid_q <= '0;
            gnt_num_q <= '0;
            done_q    <= 1'b0;
            sat_q     <= 1'b0;
            for (int i = 0; i < NUM_Q; i++) begin
                credit_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            avail_q   <= avail_d;
            rdy_q     <= rdy_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_qid_q <= gnt_qid_d;
            gnt_num_q <= gnt_num_d;
            done_q    <= done_d;
            sat_q     <= sat_d;
            for (int i = 0; i < NUM_Q; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    assign req_rdy   = rdy_q;
    assign gnt_vld   = gnt_vld_q;
    assign gnt_qid   = gnt_qid_q;
    assign gnt_num   = gnt_num_q;
    assign clr_busy  = (state_q == ST_CLEAR);
    assign clr_done  = done_q;
    assign avail_vec = avail_q;
    assign sat_err   = sat_q;

`ifdef DSC_CRD_STATS_EN
    logic [31:0] inc_cnt_q, inc_cnt_d;
    logic [31:0] sat_cnt_q, sat_cnt_d;

    // Free-running event counters; they wrap naturally at 2^32.
    always_comb begin
        inc_cnt_d = inc_ok ? (inc_cnt_q + 32'd1) : inc_cnt_q;
        sat_cnt_d = sat_d ? (sat_cnt_q + 32'd1) : sat_cnt_q;
    end

    // Counter registers.
    always_ff @(posedge axi_aclk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            inc_cnt_q <= '0;
            sat_cnt_q <= '0;
        end else begin
            inc_cnt_q <= inc_cnt_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign stat_inc_cnt = inc_cnt_q;
    assign stat_sat_cnt = sat_cnt_q;
`else
    assign stat_inc_cnt = 32'd0;
    assign stat_sat_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dma_dsc_credit_tracker.sv
// Bench for dma_dsc_credit_tracker: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-level credit model.
module tb_dma_dsc_credit_tracker;

    localparam int NUM_Q = 32;
    localparam int QID_W = 5;
    localparam int CRD_W = 16;
    localparam int MAXC  = (1 << CRD_W) - 1;
`ifdef DSC_CRD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             inc_vld;
    logic [QID_W-1:0] inc_qid;
    logic [CRD_W-1:0] inc_num;
    logic             req_vld;
    logic             req_rdy;
    logic [QID_W-1:0] req_qid;
    logic [CRD_W-1:0] req_num;
    logic             gnt_vld;
    logic [QID_W-1:0] gnt_qid;
    logic [CRD_W-1:0] gnt_num;
    logic             clr_start;
    logic             clr_busy;
    logic             clr_done;
    logic [NUM_Q-1:0] avail_vec;
    logic             sat_err;
    logic [31:0]      stat_inc_cnt;
    logic [31:0]      stat_sat_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: plain per-queue integer credits plus sweep bookkeeping.
    int unsigned m_cred [NUM_Q];
    bit          m_rdy;
    bit          m_clear;
    int          m_idx;
    int unsigned m_inc_cnt;
    int unsigned m_sat_cnt;
    bit          e_gnt, e_done, e_sat;
    int          e_gq, e_gn;

    dma_dsc_credit_tracker #(.NUM_Q(NUM_Q), .QID_W(QID_W), .CRD_W(CRD_W)) dut (
        .axi_aclk     (clk),
        .axi_reset_n  (rst_n),
        .inc_vld      (inc_vld),
        .inc_qid      (inc_qid),
        .inc_num      (inc_num),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_qid      (req_qid),
        .req_num      (req_num),
        .gnt_vld      (gnt_vld),
        .gnt_qid      (gnt_qid),
        .gnt_num      (gnt_num),
        .clr_start    (clr_start),
        .clr_busy     (clr_busy),
        .clr_done     (clr_done),
        .avail_vec    (avail_vec),
        .sat_err      (sat_err),
        .stat_inc_cnt (stat_inc_cnt),
        .stat_sat_cnt (stat_sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    function automatic logic [NUM_Q-1:0] exp_avail();
        logic [NUM_Q-1:0] v;
        for (int i = 0; i < NUM_Q; i++) v[i] = (m_cred[i] != 0);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_Q; i++) m_cred[i] = 0;
        m_rdy = 0; m_clear = 0; m_idx = 0;
        m_inc_cnt = 0; m_sat_cnt = 0;
    endtask

    task automatic check_all(input string where);
        chk({where, ".gnt_vld"}, gnt_vld, e_gnt);
        if (e_gnt) begin
            chk({where, ".gnt_qid"}, gnt_qid, e_gq);
            chk({where, ".gnt_num"}, gnt_num, e_gn);
        end
        chk({where, ".avail"},    avail_vec, exp_avail());
        chk({where, ".busy"},     clr_busy, m_clear);
        chk({where, ".done"},     clr_done, e_done);
        chk({where, ".sat"},      sat_err, e_sat);
        chk({where, ".rdy"},      req_rdy, m_rdy);
        chk({where, ".stat_inc"}, stat_inc_cnt, STATS ? m_inc_cnt : 0);
        chk({where, ".stat_sat"}, stat_sat_cnt, STATS ? m_sat_cnt : 0);
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input string where, input bit iv, input int iq, input int in_,
                        input bit rv, input int rq, input int rn, input bit cs);
        int unsigned s;
        int unsigned g;
        inc_vld = iv; inc_qid = QID_W'(iq); inc_num = CRD_W'(in_);
        req_vld = rv; req_qid = QID_W'(rq); req_num = CRD_W'(rn);
        clr_start = cs;
        e_gnt = 0; e_done = 0; e_sat = 0; e_gq = 0; e_gn = 0;
        if (!m_clear) begin
            g = 0;
            if (rv && m_rdy) g = (rn < m_cred[rq]) ? rn : m_cred[rq];
            if (iv) begin
                s = m_cred[iq] + in_;
                if (s > MAXC) begin s = MAXC; e_sat = 1; m_sat_cnt++; end
                m_cred[iq] = s;
                m_inc_cnt++;
            end
            if (rv && m_rdy) begin
                m_cred[rq] -= g;
                e_gnt = 1; e_gq = rq; e_gn = g;
            end
            if (cs) begin m_clear = 1; m_idx = 0; end
        end else begin
            m_cred[m_idx] = 0;
            if (m_idx == NUM_Q - 1) begin m_clear = 0; e_done = 1; end
            else m_idx++;
        end
        m_rdy = !m_clear;
        @(posedge clk);
        #1;
        check_all(where);
        inc_vld = 0; req_vld = 0; clr_start = 0;
    endtask

    task automatic idle(input string where);
        step(where, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string where);
        chk({where, ".rdy"},      req_rdy, 0);
        chk({where, ".gnt_vld"},  gnt_vld, 0);
        chk({where, ".gnt_qid"},  gnt_qid, 0);
        chk({where, ".gnt_num"},  gnt_num, 0);
        chk({where, ".busy"},     clr_busy, 0);
        chk({where, ".done"},     clr_done, 0);
        chk({where, ".sat"},      sat_err, 0);
        chk({where, ".avail"},    avail_vec, 0);
        chk({where, ".stat_inc"}, stat_inc_cnt, 0);
        chk({where, ".stat_sat"}, stat_sat_cnt, 0);
    endtask

    initial begin
        rst_n = 0;
        inc_vld = 0; inc_qid = '0; inc_num = '0;
        req_vld = 0; req_qid = '0; req_num = '0;
        clr_start = 0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1;
        idle("post_reset");

        // Increment q3 by 10, then consume 4
        step("r41_inc", 1, 3, 10, 0, 0, 0, 0);
        step("r41_req", 0, 0, 0, 1, 3, 4, 0);
        chk("r41_gnt_num", gnt_num, 4);
        chk("r41_avail3", avail_vec[3], 1);
        step("r41_drain", 0, 0, 0, 1, 3, 100, 0);
        chk("r41_credit3", gnt_num, 6);

        // Request more than available on q5
        step("r42_inc", 1, 5, 2, 0, 0, 0, 0);
        step("r42_req", 0, 0, 0, 1, 5, 7, 0);
        chk("r42_gnt_num", gnt_num, 2);
        chk("r42_avail5", avail_vec[5], 0);

        // Saturation on q1
        step("r43_pre", 1, 1, 'hFFF0, 0, 0, 0, 0);
        step("r43_sat", 1, 1, 'h20, 0, 0, 0, 0);
        chk("r43_sat_err", sat_err, 1);
        idle("r43_after");
        step("r43_drain", 0, 0, 0, 1, 1, 'hFFFF, 0);
        chk("r43_credit1", gnt_num, 'hFFFF);

        // Same-cycle increment and request on q2
        step("r44_pre", 1, 2, 5, 0, 0, 0, 0);
        step("r44_both", 1, 2, 3, 1, 2, 6, 0);
        chk("r44_gnt_num", gnt_num, 5);
        step("r44_drain", 0, 0, 0, 1, 2, 100, 0);
        chk("r44_credit2", gnt_num, 3);

        // Clear sweep with every queue nonzero and an increment during the sweep
        for (int q = 0; q < NUM_Q; q++) step("r45_fill", 1, q, q + 1, 0, 0, 0, 0);
        step("r45_start", 0, 0, 0, 1, 7, 1, 1);
        step("r45_inc_drop", 1, 0, 9, 1, 4, 1, 0);
        for (int c = 1; c < NUM_Q; c++) step("r45_sweep", 0, 0, 0, 0, 0, 0, c == 3);
        chk("r45_avail_zero", avail_vec, 0);
        step("r45_q0_read", 0, 0, 0, 1, 0, 50, 0);
        chk("r45_q0_dropped", gnt_num, 0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            bit iv, rv, cs;
            int iq, rq, in_, rn;
            iv  = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 2) != 0);
            cs  = ($urandom_range(0, 79) == 0);
            iq  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NUM_Q - 1) : $urandom_range(0, 3);
            rq  = ($urandom_range(0, 1) == 0) ? iq : $urandom_range(0, 3);
            in_ = ($urandom_range(0, 7) == 0) ? $urandom_range(MAXC - 64, MAXC) : $urandom_range(0, 40);
            rn  = $urandom_range(0, 60);
            step("rand", iv, iq, in_, rv, rq, rn, cs);
        end
        while (m_clear) idle("rand_tail");

        // Reset in the middle of a sweep at index 10
        for (int q = 0; q < NUM_Q; q++) step("r46_fill", 1, q, 3, 0, 0, 0, 0);
        step("r46_start", 0, 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 10; c++) idle("r46_sweep");
        chk("r46_idx", m_idx, 10);
        #2;
        rst_n = 0;
        #1;
        check_reset_outputs("r46_in_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("r46_held");
        #2;
        rst_n = 1;
        idle("r46_release");
        chk("r46_rdy", req_rdy, 1);
        idle("r46_quiet");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dma_dsc_credit_tracker.md
DMA_DSC_CREDIT_TRACKER -- requirements
Module: dma_dsc_credit_tracker

Interface
REQ-001 Parameter NUM_Q, default 32: number of tracked queues, power of two, range 2..256.
REQ-002 Parameter QID_W, default 5: queue-id width, equal to log2(NUM_Q).
REQ-003 Parameter CRD_W, default 16: per-queue credit counter width; also the width of the num fields.
REQ-004 Port axi_aclk, input, 1: sole clock; all logic is rising-edge.
REQ-005 Port axi_reset_n, input, 1: asynchronous active-low reset.
REQ-006 Port inc_vld, input, 1: descriptor-available increment strobe; no backpressure.
REQ-007 Port inc_qid, input, QID_W: queue receiving the increment.
REQ-008 Port inc_num, input, CRD_W: number of descriptors added.
REQ-009 Port req_vld, input, 1: consume request valid.
REQ-010 Port req_rdy, output, 1: consume request ready.
REQ-011 Port req_qid, input, QID_W: queue to consume from.
REQ-012 Port req_num, input, CRD_W: descriptors requested.
REQ-013 Port gnt_vld, output, 1: grant strobe, single cycle.
REQ-014 Port gnt_qid, output, QID_W: queue of the grant.
REQ-015 Port gnt_num, output, CRD_W: descriptors granted; may be 0.
REQ-016 Port clr_start, input, 1: single-cycle pulse that starts a full-table clear (FLR).
REQ-017 Port clr_busy, output, 1: clear sweep in progress.
REQ-018 Port clr_done, output, 1: single-cycle pulse when the sweep completes.
REQ-019 Port avail_vec, output, NUM_Q: bit q is high iff credit[q] is nonzero.
REQ-020 Port sat_err, output, 1: single-cycle pulse when an increment saturates.
REQ-021 Port stat_inc_cnt, output, 32: accepted-increment count.
REQ-022 Port stat_sat_cnt, output, 32: saturation-event count.

Function
REQ-023 The table SHALL hold NUM_Q credit registers of CRD_W bits each.
REQ-024 When inc_vld is high in IDLE, credit[inc_qid] SHALL add inc_num, saturating at 2^CRD_W-1; any clipped add SHALL pulse sat_err in the following cycle.
REQ-025 A request SHALL be accepted on a cycle where req_vld and req_rdy are both high; req_rdy SHALL equal (state==IDLE).
REQ-026 Exactly one cycle after acceptance, gnt_vld SHALL pulse with gnt_qid=req_qid and gnt_num=min(req_num, credit[req_qid]) sampled at acceptance.
REQ-027 The credit of the accepted queue SHALL drop by gnt_num in the same edge that registers the grant.
REQ-028 If an increment and an accepted request hit the same queue in the same cycle, the grant SHALL use the pre-increment credit, and the new value SHALL be sat(credit+inc_num)-gnt_num, with saturation applied before the subtraction.
REQ-029 The FSM SHALL have states IDLE and CLEAR; clr_start in IDLE SHALL enter CLEAR with sweep index 0.
REQ-030 In CLEAR, one queue SHALL be zeroed per cycle in ascending order; after queue NUM_Q-1 the FSM SHALL return to IDLE and pulse clr_done in the cycle it enters IDLE.
REQ-031 clr_busy SHALL equal (state==CLEAR); clr_start while in CLEAR SHALL be ignored.
REQ-032 Increments arriving in CLEAR SHALL be dropped; no requests are accepted in CLEAR.
REQ-033 A clr_start coincident with an accepted request SHALL still issue that grant normally.
REQ-034 avail_vec SHALL be registered and reflect the table state after each edge.

Reset
REQ-035 While axi_reset_n is low, every credit register and the sweep index SHALL be 0, and the state SHALL be IDLE.
REQ-036 While axi_reset_n is low, gnt_vld, gnt_qid, gnt_num, clr_busy, clr_done, sat_err, avail_vec and both stat counters SHALL be 0, and req_rdy SHALL be 0.
REQ-037 A reset asserted mid-sweep or with a grant pending SHALL abort it with no clr_done or gnt_vld pulse.
REQ-038 req_rdy SHALL go to 1 on the first edge after reset deasserts.

Configuration
REQ-039 With macro DSC_CRD_STATS_EN defined, stat_inc_cnt SHALL count accepted increments, stat_sat_cnt SHALL count sat_err pulses, and both SHALL wrap at 2^32.
REQ-040 With DSC_CRD_STATS_EN undefined, both stat ports SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-041 Increment q3 by 10, then request q3 num 4 -> gnt_num=4 one cycle later; credit[3]=6; avail_vec[3]=1.
REQ-042 Credit q5=2, request q5 num 7 -> gnt_num=2; avail_vec[5]=0.
REQ-043 Credit q1=0xFFF0 (CRD_W=16), increment 0x20 -> credit 0xFFFF; sat_err pulses once; stat_sat_cnt=1 with the macro.
REQ-044 Credit q2=5, same-cycle increment 3 and request 6 on q2 -> gnt_num=5; credit[2]=3.
REQ-045 clr_start with all queues nonzero; increment q0 during the sweep -> clr_busy held for 32 cycles; clr_done pulses once; avail_vec=0; the increment is dropped.
REQ-046 Reset asserted at sweep index 10 -> all outputs 0 immediately; no clr_done; req_rdy=1 after release.
